// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// an occupancy count, sticky overflow/underflow flags and a selectable
// first-word-fall-through read mode.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst          - synchronous active-high reset
//   wr_en        - write request
//   rd_en        - read (pop) request
//   data_in      - write data
//   clr_err      - clears overflow/underflow at the next edge
//   data_out     - read data (registered in standard mode, head word in FWFT)
//   full         - count == DEPTH
//   empty        - count == 0
//   almost_full  - count >= AF_THRESH
//   almost_empty - count <= AE_THRESH
//   count        - number of stored words, 0..DEPTH
//   overflow     - sticky, a write was rejected
//   underflow    - sticky, a read was rejected
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_THRESH);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_range
    $error("fifo_sync_prog: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_range
    $error("fifo_sync_prog: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  rd_acc;
  logic                  wr_acc;

  // Flags decode from the registered count only, so they never glitch.
  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_CNT);
  assign almost_full  = (cnt >= AF_CNT);
  assign almost_empty = (cnt <= AE_CNT);
  assign count        = cnt;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A write into a full FIFO is still taken when a read frees a slot
  // in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Storage is never reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A fresh error outranks a same-cycle clear.
      ovf_q <= (ovf_q & ~clr_err) | (wr_en & ~wr_acc);
      udf_q <= (udf_q & ~clr_err) | (rd_en & ~rd_acc);
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word comes straight from the registered array, never from data_in.
    // An empty FIFO presents zero rather than stale storage.
    assign data_out = empty ? '0 : mem[rptr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem[rptr];
      end
    end
    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_fifo_sync_prog.sv
module tb_fifo_sync_prog;

  localparam int DEPTH = 64;
  localparam int AF    = 60;
  localparam int AE    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       clr_err = 1'b0;

  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ov0, uf0;
  logic       full1, empty1, af1, ae1, ov1, uf1;
  logic [6:0] cnt0, cnt1;

  always #5 clk = ~clk;

  fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .clr_err(clr_err),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ov0), .underflow(uf0)
  );

  fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .clr_err(clr_err),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ov1), .underflow(uf1)
  );

  typedef struct {
    int       cnt;
    bit       full, empty, af, ae, ov, uf;
    bit [7:0] d0;
    bit       f1_chk;
    bit [7:0] d1;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] mq[$];
  bit       m_ov = 1'b0;
  bit       m_uf = 1'b0;
  bit [7:0] m_dout = 8'h00;
  int       errors = 0;
  int       checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the acceptance rules; expected state
  // after each edge is queued for the monitor.
  task automatic step(bit r, bit w, bit rd, bit [7:0] din, bit clr);
    bit   wr_ok, rd_ok;
    exp_t e;
    rst = r; wr_en = w; rd_en = rd; data_in = din; clr_err = clr;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ov = 1'b0;
      m_uf = 1'b0;
      m_dout = 8'h00;
    end else begin
      rd_ok = rd && (mq.size() > 0);
      wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
      m_ov = (m_ov && !clr) || (w && !wr_ok);
      m_uf = (m_uf && !clr) || (rd && !rd_ok);
      if (rd_ok) m_dout = mq.pop_front();
      if (wr_ok) mq.push_back(din);
    end
    e.cnt    = mq.size();
    e.full   = (mq.size() == DEPTH);
    e.empty  = (mq.size() == 0);
    e.af     = (mq.size() >= AF);
    e.ae     = (mq.size() <= AE);
    e.ov     = m_ov;
    e.uf     = m_uf;
    e.d0     = m_dout;
    e.f1_chk = r || (mq.size() > 0);
    e.d1     = (mq.size() > 0) ? mq[0] : 8'h00;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("std_count", 32'(cnt0), 32'(e.cnt));
        chk("std_full", 32'(full0), 32'(e.full));
        chk("std_empty", 32'(empty0), 32'(e.empty));
        chk("std_almost_full", 32'(af0), 32'(e.af));
        chk("std_almost_empty", 32'(ae0), 32'(e.ae));
        chk("std_overflow", 32'(ov0), 32'(e.ov));
        chk("std_underflow", 32'(uf0), 32'(e.uf));
        chk("std_data_out", 32'(dout0), 32'(e.d0));
        chk("fwft_count", 32'(cnt1), 32'(e.cnt));
        chk("fwft_empty", 32'(empty1), 32'(e.empty));
        chk("fwft_full", 32'(full1), 32'(e.full));
        chk("fwft_almost_full", 32'(af1), 32'(e.af));
        chk("fwft_almost_empty", 32'(ae1), 32'(e.ae));
        chk("fwft_overflow", 32'(ov1), 32'(e.ov));
        chk("fwft_underflow", 32'(uf1), 32'(e.uf));
        if (e.f1_chk) chk("fwft_data_out", 32'(dout1), 32'(e.d1));
      end
    end
  end

  initial begin : driver
    int pw;
    // reset
    step(1, 0, 0, 8'h00, 0);
    step(1, 1, 1, 8'h99, 0);
    // fill, overflow, error clear
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(i), 0);
    step(0, 1, 0, 8'hAA, 0);
    step(0, 0, 0, 8'h00, 1);
    step(0, 1, 0, 8'hAA, 0);
    step(0, 1, 0, 8'hAA, 1);
    step(0, 0, 0, 8'h00, 1);
    // simultaneous at full, then drain
    step(0, 1, 1, 8'h55, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00, 0);
    step(0, 0, 1, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);
    // simultaneous at empty
    step(0, 1, 1, 8'h77, 0);
    step(0, 0, 1, 8'h00, 1);
    // fall-through sequence
    step(0, 1, 0, 8'h12, 0);
    step(0, 0, 1, 8'h00, 0);
    step(0, 1, 0, 8'h12, 0);
    step(0, 1, 0, 8'h34, 0);
    step(0, 0, 1, 8'h00, 0);
    step(0, 0, 1, 8'h00, 0);
    // wrap-around at occupancy 10
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'($urandom), 0);
    for (int i = 0; i < 200; i++) step(0, 1, 1, 8'($urandom), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h00, 0);
    // random traffic with phases biased toward full and toward empty
    for (int i = 0; i < 3000; i++) begin
      pw = ((i / 300) % 2 == 0) ? 80 : 25;
      if (i == 1500 || i == 1501) begin
        step(1, $urandom_range(99) < pw, $urandom_range(1), 8'($urandom), 0);
      end else begin
        step(0, $urandom_range(99) < pw, $urandom_range(99) < 50, 8'($urandom),
             $urandom_range(99) < 3);
      end
    end
    // reset mid-traffic with content, then a read must underflow
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(i + 1), 0);
    step(1, 1, 0, 8'hEE, 0);
    step(1, 0, 1, 8'h00, 0);
    step(0, 0, 1, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_prog.md
# fifo_sync_prog

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It is the synchronous-domain companion to the team's asynchronous FIFO. It buffers a data stream between two blocks sharing `clk`, and keeps the same `wr_en`/`rd_en`/`data_in`/`data_out`/`full`/`empty` signal set so existing bus-functional models drive it unchanged.

## Interface
- `DATA_WIDTH`, default 8: word width.
- `ADDR_WIDTH`, default 6: address width; DEPTH = 2**ADDR_WIDTH (64).
- `AF_THRESH`, default DEPTH-4: `almost_full` asserts when count >= AF_THRESH; legal range 1..DEPTH.
- `AE_THRESH`, default 4: `almost_empty` asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- `FWFT`, default 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: one clock; reset is synchronous and active-high.
- `wr_en` input 1: write request.
- `rd_en` input 1: read (pop) request.
- `data_in` input DATA_WIDTH: write data.
- `clr_err` input 1: synchronous clear of the sticky error flags.
- `data_out` output DATA_WIDTH: read data.
- `full` output 1: count == DEPTH.
- `empty` output 1: no word readable (see Operation).
- `almost_full` output 1: count >= AF_THRESH.
- `almost_empty` output 1: count <= AE_THRESH.
- `count` output ADDR_WIDTH+1: stored words, 0..DEPTH.
- `overflow` output 1: sticky; a write was rejected.
- `underflow` output 1: sticky; a read was rejected.

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset. Write and read pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally. `count` is held in its own register; it is not derived from pointer difference.
- Write accept = `wr_en` & (!`full` | read accepted this cycle). A rejected write sets `overflow`. Memory and pointers are unchanged.
- Read accept = `rd_en` & !`empty`. A rejected read sets `underflow`. Pointers and `data_out` are unchanged.
- Full with `wr_en` & `rd_en`: both are accepted, count stays DEPTH, no overflow.
- Empty with `wr_en` & `rd_en`: only the write is accepted, `underflow` is set, and count becomes 1.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags `full`, `almost_full` and `almost_empty` decode combinationally from the registered `count`, so they are glitch-free relative to `clk`.
- FWFT=0:
  - `empty` = (count == 0).
  - On an accepted read, `data_out` <= mem[rptr] at the next edge. Otherwise `data_out` holds.
- FWFT=1:
  - `data_out` continuously presents the head word.
  - `empty` = (count == 0).
  - `rd_en` acknowledges and pops the presented word. The next word appears in the same edge's update.
  - The write-to-visible path must not combinationally bypass `data_in`.
- `clr_err`: clears `overflow`/`underflow` at the next edge. A new error in the same cycle wins, and the flag stays 1.
- Thresholds are compile-time only. Out-of-range values are flagged by an elaboration-time assertion.

## Timing
- Reset (`rst`=1 at an edge):
  - wptr = rptr = 0, count = 0.
  - `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0, `data_out`=0.
  - Reset overrides any same-cycle `wr_en`/`rd_en`. Reset mid-stream discards all contents.
- Write latency: a word written at edge N is readable from edge N; `empty` deasserts after edge N.
  - FWFT=1: `data_out` shows that word after edge N.
  - FWFT=0: `data_out` updates at edge N+1 after a read at N+1.
- Read latency:
  - FWFT=0: one cycle from `rd_en` sample to `data_out`.
  - FWFT=1: zero cycles (the data is already present).
- Flags update at the same edge as `count`. There is no extra pipeline stage.
- Sustained throughput: one write and one read per cycle at any occupancy, including full.

## Test plan
- Reset: assert `rst` 2 cycles mid-traffic -> count=0, `empty`=1, `almost_empty`=1, `full`=0, `overflow`=`underflow`=0, `data_out`=0; a following read sets `underflow`.
- Fill/overflow: write 0x00..0x3F (64 words) -> `almost_full` at count 60, `full` at 64; 65th write 0xAA -> rejected, `overflow`=1, count=64. Drain -> reads return 0x00..0x3F in order; `almost_empty` at count 4; `empty` at 0.
- Simultaneous at boundaries: at full, `wr_en`&`rd_en` with 0x55 -> count stays 64, no overflow, 0x55 read last. At empty, both -> count=1, `underflow`=1.
- Wrap-around: 200 continuous writes and reads at occupancy 10 -> data order preserved across pointer wrap; count constant 10.
- Error clear: raise `overflow`, pulse `clr_err` -> 0 next cycle. Pulse `clr_err` with a same-cycle rejected write -> `overflow` stays 1.
- FWFT=1 build: write 0x12 -> `data_out`=0x12 after that edge with `empty`=0; `rd_en` pops it; back-to-back 0x12, 0x34 -> 0x34 presented immediately after the pop.
